// File: rtl/key_schedule_sequencer.sv
// DES round-key sequencer: latches a cipher key, walks the external subkey
// generator through rounds 0..15 and banks the 16 subkeys for round-indexed reads.
module key_schedule_sequencer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_key_valid,
  input  logic [63:0] i_64bit_key,
  output logic        o_key_ready,
  output logic [63:0] o_64bit_key,
  output logic [3:0]  o_round,
  input  logic [47:0] i_48bit_key,
  input  logic        i_decrypt,
  input  logic [3:0]  i_rd_round,
  output logic [47:0] o_rd_key,
  output logic        o_keys_valid,
  output logic        o_done
);

  // Key handshake: a key transfers on a rising edge where i_key_valid and
  // o_key_ready are both high; o_key_ready depends on state only.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GEN   = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [63:0] r_key;
  logic [47:0] r_bank [16];
  logic [47:0] r_rd_key;
  logic        r_done;
  logic        w_accept;
  logic        w_last;
  logic [3:0]  w_rd_idx;

  assign o_key_ready  = (r_state != S_GEN);
  assign o_keys_valid = (r_state == S_READY);
  assign o_round      = (r_state == S_GEN) ? r_cnt : 4'd0;
  assign o_64bit_key  = r_key;
  assign o_rd_key     = r_rd_key;
  assign o_done       = r_done;

  assign w_accept = i_key_valid & o_key_ready;
  assign w_last   = (r_state == S_GEN) && (r_cnt == 4'd15);
  assign w_rd_idx = i_decrypt ? (4'd15 - i_rd_round) : i_rd_round;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_GEN;
      S_GEN:   if (r_cnt == 4'd15) w_next = S_READY;
      S_READY: if (w_accept) w_next = S_GEN;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= 4'd0;
      r_key    <= 64'd0;
      r_done   <= 1'b0;
      r_rd_key <= 48'd0;
      for (int i = 0; i < 16; i++) begin
        r_bank[i] <= 48'd0;
      end
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_key <= i_64bit_key;
        r_cnt <= 4'd0;
      end else if (r_state == S_GEN) begin
        r_bank[r_cnt] <= i_48bit_key;
        if (r_cnt != 4'd15) begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
      // Reads use the pre-edge bank, so a reload edge still returns the old key's subkey.
      r_rd_key <= o_keys_valid ? r_bank[w_rd_idx] : 48'd0;
    end
  end

endmodule

// File: doc/key_schedule_sequencer.md
# key_schedule_sequencer

Sequences the DES round-key generation and buffers the results. It latches a 64-bit cipher key and drives round indices 0..15 (DES rounds 1..16) into the combinational round-key generator. It captures each returned 48-bit subkey into a 16-entry bank. The round datapath then reads subkeys by round number, in forward order for encryption or reversed order for decryption.

## Interface
Parameters:
- None; widths are fixed by DES (64-bit key, 48-bit subkey, 16 rounds).

Ports:
- i_clk  input  1  — single clock; all state updates on rising edge.
- i_rst  input  1  — synchronous, active-high reset.
- i_key_valid  input  1  — upstream offers a new 64-bit key.
- i_64bit_key  input  64  — cipher key, parity bits included.
- o_key_ready  output  1  — block can accept a key; a key is accepted when i_key_valid & o_key_ready at a rising edge.
- o_64bit_key  output  64  — latched key, wired to the generator's key input.
- o_round  output  4  — round index, wired to the generator's round input.
- i_48bit_key  input  48  — generator's subkey for o_round; combinational, same cycle.
- i_decrypt  input  1  — 1 selects the reversed read order.
- i_rd_round  input  4  — round index requested by the datapath.
- o_rd_key  output  48  — registered subkey for the request sampled on the previous edge.
- o_keys_valid  output  1  — all 16 subkeys are present for the current key.
- o_done  output  1  — one-cycle pulse when the bank is complete.

## Operation
- FSM states:
  - IDLE: o_key_ready=1; o_keys_valid=0.
  - GEN: o_key_ready=0.
  - READY: o_key_ready=1; o_keys_valid=1.
- IDLE, key accepted: o_64bit_key <= i_64bit_key; cnt <= 0; go to GEN.
- GEN: o_round = cnt.
  - Each edge writes bank[cnt] <= i_48bit_key.
  - If cnt==15, go to READY and set o_done=1; otherwise cnt <= cnt+1.
- READY, key accepted: latch the new key; cnt <= 0; go to GEN; o_keys_valid falls.
- READY with no new key: remain in READY indefinitely; the bank is stable.
- In IDLE/READY, o_round holds 0 and is ignored downstream.
- i_key_valid during GEN is ignored; it is not queued. Upstream must hold it until o_key_ready.
- Read path, registered on every edge:
  - If o_keys_valid=0: o_rd_key <= 0.
  - Else: o_rd_key <= bank[i_decrypt ? 15 - i_rd_round : i_rd_round]. The subtraction is 4-bit unsigned and does not wrap (15-0=15, 15-15=0).
- Read vs load in the same cycle: in a READY cycle where a new key is accepted, the read sampled on that edge returns the old key's subkey. Slot 0 is first overwritten one edge later.
- Reset, in any state including mid-GEN:
  - state=IDLE; cnt=0; all 16 bank entries = 0.
  - Outputs: o_64bit_key=0, o_round=0, o_rd_key=0, o_keys_valid=0, o_done=0, o_key_ready=1 in the cycle after the reset edge.
  - Any partial schedule is discarded.

## Timing
- Accept at edge N.
  - Cycles N+1..N+16 are GEN with o_round = 0,1,…,15.
  - Captures occur at edges N+1..N+16.
- After edge N+16: state READY; o_done=1 for exactly that cycle; o_keys_valid=1 from that cycle on.
- Key-to-bank latency: 16 cycles. Back-to-back keys: one every 17 cycles minimum, since READY lasts at least one cycle.
- Read latency: 1 cycle (i_rd_round sampled at edge M, o_rd_key valid after edge M).
- o_key_ready is derived from state only, with no combinational path from i_key_valid.

## Test plan
- Reset, then idle 5 cycles -> o_key_ready=1, o_keys_valid=0, o_rd_key=0, o_done never asserted.
- Load key 0x133457799BBCDFF1 -> o_round steps 0..15 over 16 cycles; o_done pulses once; read i_rd_round=0, i_decrypt=0 -> 0x1B02EFFC7072; read i_rd_round=15 -> 0xCB3D8B0E17F5.
- Same key, i_decrypt=1: i_rd_round=0 -> 0xCB3D8B0E17F5; i_rd_round=15 -> 0x1B02EFFC7072; sweep 0..15 -> exactly the forward sequence reversed.
- Hold i_key_valid high with a second key during GEN -> ignored until READY; accepted on the first READY cycle; read issued that same cycle returns the first key's subkey; o_keys_valid falls the next cycle.
- Assert i_rst at GEN cycle 7 -> next cycle IDLE; o_round=0; all bank entries read 0 after the next full load of a different key except the entries rewritten; o_done not pulsed for the aborted key.
- Key 0x0000000000000000 -> all 16 subkeys read 0x000000000000; o_done pulses 16 cycles after accept.
